// File: rtl/cdb_arbiter.sv
// Common data bus transmitter: buffers functional-unit results in small
// per-source FIFOs and broadcasts one result per cycle, chosen round-robin,
// on a registered CDB that the ROB and reservation stations snoop.

package cdb_pkg;
  typedef struct packed {
    logic        valid;
    logic [4:0]  rd_addr;
    logic [4:0]  rob_idx;
    logic [31:0] data;
  } cdb_t;
endpackage

module cdb_arbiter #(
  parameter int NUM_SRC    = 3,
  parameter int FIFO_DEPTH = 2,
  parameter int ROB_IDX_W  = 5
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_SRC-1:0]                  fu_valid_i,
  output logic [NUM_SRC-1:0]                  fu_ready_o,
  input  logic [NUM_SRC-1:0][4:0]             fu_rd_addr_i,
  input  logic [NUM_SRC-1:0][ROB_IDX_W-1:0]   fu_rob_idx_i,
  input  logic [NUM_SRC-1:0][31:0]            fu_data_i,
  input  logic                                flush_i,
  output cdb_pkg::cdb_t                       cdbus_o,
  output logic [NUM_SRC-1:0]                  grant_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef struct packed {
    logic [4:0]           rd_addr;
    logic [ROB_IDX_W-1:0] rob_idx;
    logic [31:0]          data;
  } entry_t;

  entry_t             r_mem   [NUM_SRC][FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wrPtr [NUM_SRC];
  logic [PTR_W-1:0]   r_rdPtr [NUM_SRC];
  logic [CNT_W-1:0]   r_count [NUM_SRC];
  logic [SRC_W-1:0]   r_rrPtr;
  cdb_pkg::cdb_t      r_cdbus;
  logic [NUM_SRC-1:0] r_grant;

  logic [NUM_SRC-1:0] w_ready;
  logic [NUM_SRC-1:0] w_push;
  logic [NUM_SRC-1:0] w_pop;
  logic [NUM_SRC-1:0] w_notEmpty;
  logic               w_grantValid;
  logic [SRC_W-1:0]   w_grantIdx;
  entry_t             w_head;

  // Source index reached by stepping 'offset' places up from 'base', wrapping at NUM_SRC.
  function automatic logic [SRC_W-1:0] wrapIdx(input logic [SRC_W-1:0] base, input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= NUM_SRC) sum = sum - NUM_SRC;
    return SRC_W'(sum);
  endfunction

  // Ready depends only on stored counts, flush and reset, so a same-cycle pop never raises it.
  always_comb begin
    w_ready    = '0;
    w_push     = '0;
    w_notEmpty = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_notEmpty[i] = (r_count[i] != '0);
      w_ready[i]    = (r_count[i] != FULL_CNT) && !flush_i && rst;
      w_push[i]     = fu_valid_i[i] && w_ready[i];
    end
  end

  assign fu_ready_o = w_ready;

  // First non-empty FIFO at or above the round-robin pointer, wrapping, wins the bus.
  always_comb begin
    w_grantValid = 1'b0;
    w_grantIdx   = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!w_grantValid && w_notEmpty[wrapIdx(r_rrPtr, k)]) begin
        w_grantValid = 1'b1;
        w_grantIdx   = wrapIdx(r_rrPtr, k);
      end
    end
  end

  // The winner's head entry is popped at the edge it is broadcast on.
  always_comb begin
    w_pop  = '0;
    w_head = r_mem[w_grantIdx][r_rdPtr[w_grantIdx]];
    for (int i = 0; i < NUM_SRC; i++) begin
      w_pop[i] = w_grantValid && (w_grantIdx == SRC_W'(i));
    end
  end

  // FIFO pointers and occupancy; flush empties every FIFO ahead of any push or pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        r_wrPtr[i] <= '0;
        r_rdPtr[i] <= '0;
        r_count[i] <= '0;
      end
    end else if (flush_i) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        r_wrPtr[i] <= '0;
        r_rdPtr[i] <= '0;
        r_count[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (w_push[i]) r_wrPtr[i] <= r_wrPtr[i] + PTR_W'(1);
        if (w_pop[i])  r_rdPtr[i] <= r_rdPtr[i] + PTR_W'(1);
        case ({w_push[i], w_pop[i]})
          2'b10:   r_count[i] <= r_count[i] + CNT_W'(1);
          2'b01:   r_count[i] <= r_count[i] - CNT_W'(1);
          default: r_count[i] <= r_count[i];
        endcase
      end
    end
  end

  // FIFO storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_push[i]) r_mem[i][r_wrPtr[i]] <= {fu_rd_addr_i[i], fu_rob_idx_i[i], fu_data_i[i]};
    end
  end

  // Registered broadcast and priority rotation; idle cycles clear only valid and grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rrPtr <= '0;
      r_cdbus <= '0;
      r_grant <= '0;
    end else if (flush_i) begin
      r_rrPtr       <= '0;
      r_cdbus.valid <= 1'b0;
      r_grant       <= '0;
    end else if (w_grantValid) begin
      r_rrPtr         <= (w_grantIdx == SRC_W'(NUM_SRC - 1)) ? '0 : w_grantIdx + SRC_W'(1);
      r_cdbus.valid   <= 1'b1;
      r_cdbus.rd_addr <= w_head.rd_addr;
      r_cdbus.rob_idx <= 5'(w_head.rob_idx);
      r_cdbus.data    <= w_head.data;
      r_grant         <= NUM_SRC'(1) << w_grantIdx;
    end else begin
      r_cdbus.valid <= 1'b0;
      r_grant       <= '0;
    end
  end

  assign cdbus_o = r_cdbus;
  assign grant_o = r_grant;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: handshakes push expected results into
// per-source queues, a negedge monitor pops and compares every broadcast.

module tb_cdb_arbiter;
  import cdb_pkg::*;

  localparam int NS = 3;

  typedef struct packed {
    logic [4:0]  rd;
    logic [4:0]  rob;
    logic [31:0] data;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst;
  logic [NS-1:0]       fu_valid_i;
  logic [NS-1:0]       fu_ready_o;
  logic [NS-1:0][4:0]  fu_rd_addr_i;
  logic [NS-1:0][4:0]  fu_rob_idx_i;
  logic [NS-1:0][31:0] fu_data_i;
  logic                flush_i;
  cdb_t                cdbus_o;
  logic [NS-1:0]       grant_o;

  int checks   = 0;
  int failures = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  logic [NS-1:0] grantLog[$];

  logic [NS-1:0] hs;
  int            seq[NS];
  int            monSrc;
  exp_t          monExp;

  cdb_arbiter #(.NUM_SRC(NS), .FIFO_DEPTH(2), .ROB_IDX_W(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .fu_valid_i   (fu_valid_i),
    .fu_ready_o   (fu_ready_o),
    .fu_rd_addr_i (fu_rd_addr_i),
    .fu_rob_idx_i (fu_rob_idx_i),
    .fu_data_i    (fu_data_i),
    .flush_i      (flush_i),
    .cdbus_o      (cdbus_o),
    .grant_o      (grant_o)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic pushExp(input int s, input exp_t e);
    case (s)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  function automatic int qSize(input int s);
    case (s)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic clearExp();
    q0.delete();
    q1.delete();
    q2.delete();
  endtask

  task automatic setData(input int s, input logic [4:0] rd, input logic [4:0] rob, input logic [31:0] d);
    fu_rd_addr_i[s] = rd;
    fu_rob_idx_i[s] = rob;
    fu_data_i[s]    = d;
  endtask

  // Drive one cycle of valids/flush, log expected results for accepted handshakes, return after the edge.
  task automatic applyStimulus(input logic [NS-1:0] v, input logic fl, output logic [NS-1:0] accepted);
    fu_valid_i = v;
    flush_i    = fl;
    @(negedge clk);
    accepted = v & fu_ready_o;
    for (int i = 0; i < NS; i++) begin
      if (accepted[i]) pushExp(i, {fu_rd_addr_i[i], fu_rob_idx_i[i], fu_data_i[i]});
    end
    @(posedge clk);
    #1;
    fu_valid_i = '0;
    flush_i    = 1'b0;
    if (fl) clearExp();
  endtask

  task automatic idleCycles(input int n);
    logic [NS-1:0] dummy;
    for (int i = 0; i < n; i++) applyStimulus('0, 1'b0, dummy);
  endtask

  task automatic resetDut();
    rst        = 1'b0;
    fu_valid_i = '0;
    flush_i    = 1'b0;
    clearExp();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Monitor: every broadcast must match the oldest outstanding result of the granted source.
  always @(negedge clk) begin
    if (cdbus_o.valid === 1'b1) begin
      grantLog.push_back(grant_o);
      checkOutput("grant_onehot", 64'($countones(grant_o)), 64'd1);
      if ($countones(grant_o) == 1) begin
        monSrc = (grant_o[0] === 1'b1) ? 0 : (grant_o[1] === 1'b1) ? 1 : 2;
        if (qSize(monSrc) == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_broadcast: src %0d sent 0x%0h, nothing outstanding at %0t",
                   monSrc, cdbus_o, $time);
        end else begin
          case (monSrc)
            0: monExp = q0.pop_front();
            1: monExp = q1.pop_front();
            default: monExp = q2.pop_front();
          endcase
          checkOutput("cdb_payload", 64'({cdbus_o.rd_addr, cdbus_o.rob_idx, cdbus_o.data}), 64'(monExp));
        end
      end
    end else begin
      checkOutput("idle_grant", 64'(grant_o), 64'd0);
    end
  end

  // Directed test sequence.
  initial begin
    logic [4:0]    rdTab   [6] = '{5'd8, 5'd9, 5'd10, 5'd0, 5'd0, 5'd0};
    logic [4:0]    robTab  [6] = '{5'd16, 5'd17, 5'd18, 5'd4, 5'd5, 5'd6};
    logic [31:0]   dataTab [6] = '{32'h11110000, 32'h22220000, 32'h33330000, 32'hB0, 32'hB1, 32'hB2};
    logic [NS-1:0] readyTab[6] = '{3'b111, 3'b111, 3'b001, 3'b010, 3'b100, 3'b001};
    logic [NS-1:0] t4Tab   [7] = '{3'b010, 3'b100, 3'b001, 3'b100, 3'b001, 3'b100, 3'b001};
    logic [NS-1:0] t5Tab   [3] = '{3'b001, 3'b010, 3'b100};

    rst          = 1'b1;
    fu_valid_i   = '0;
    flush_i      = 1'b0;
    fu_rd_addr_i = '0;
    fu_rob_idx_i = '0;
    fu_data_i    = '0;

    // Reset state
    #1 rst = 1'b0;
    #2;
    checkOutput("reset_cdbus", 64'(cdbus_o), 64'd0);
    checkOutput("reset_grant", 64'(grant_o), 64'd0);
    checkOutput("reset_ready", 64'(fu_ready_o), 64'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #3;
    checkOutput("ready_after_reset", 64'(fu_ready_o), 64'h7);

    // Single source, single result: visible two cycles after the handshake
    setData(1, 5'd5, 5'd3, 32'hDEADBEEF);
    applyStimulus(3'b010, 1'b0, hs);
    checkOutput("t1_handshake", 64'(hs), 64'h2);
    #2;
    checkOutput("t1_not_yet", 64'(cdbus_o.valid), 64'd0);
    idleCycles(1);
    #2;
    checkOutput("t1_cdbus", 64'(cdbus_o), 64'({1'b1, 5'd5, 5'd3, 32'hDEADBEEF}));
    checkOutput("t1_grant", 64'(grant_o), 64'h2);
    idleCycles(1);
    #2;
    checkOutput("t1_one_pulse", 64'(cdbus_o.valid), 64'd0);

    // Simultaneous sources, twice: second round proves rr_ptr came back to 0
    resetDut();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < NS; i++) setData(i, rdTab[r*3+i], robTab[r*3+i], dataTab[r*3+i]);
      applyStimulus(3'b111, 1'b0, hs);
      checkOutput("t2_handshake", 64'(hs), 64'h7);
      idleCycles(1);
      for (int k = 0; k < NS; k++) begin
        #2;
        checkOutput("t2_grant", 64'(grant_o), 64'(3'b001 << k));
        checkOutput("t2_cdbus", 64'(cdbus_o), 64'({1'b1, rdTab[r*3+k], robTab[r*3+k], dataTab[r*3+k]}));
        idleCycles(1);
      end
      #2;
      checkOutput("t2_idle_after", 64'(cdbus_o.valid), 64'd0);
    end

    // Backpressure: three streaming sources, six results each
    resetDut();
    grantLog.delete();
    for (int i = 0; i < NS; i++) seq[i] = 0;
    for (int c = 0; c < 24; c++) begin
      logic [NS-1:0] v;
      for (int i = 0; i < NS; i++) begin
        v[i] = (seq[i] < 6);
        setData(i, 5'(seq[i] + 1), 5'(i * 8 + seq[i]), 32'hC0000000 | (i << 16) | seq[i]);
      end
      if (c < 6) begin
        #2;
        checkOutput("t3_ready", 64'(fu_ready_o), 64'(readyTab[c]));
      end
      applyStimulus(v, 1'b0, hs);
      for (int i = 0; i < NS; i++) seq[i] += int'(hs[i]);
    end
    checkOutput("t3_broadcast_count", 64'(grantLog.size()), 64'd18);
    for (int k = 0; k < grantLog.size() && k < 18; k++) begin
      checkOutput("t3_rr_order", 64'(grantLog[k]), 64'(3'b001 << (k % 3)));
    end
    for (int i = 0; i < NS; i++) begin
      checkOutput("t3_all_sent", 64'(seq[i]), 64'd6);
      checkOutput("t3_all_seen", 64'(qSize(i)), 64'd0);
    end

    // Pointer wrap: src1 moves rr_ptr to 2, then src2 and src0 alternate
    resetDut();
    grantLog.delete();
    setData(1, 5'd1, 5'd1, 32'h0000_0001);
    applyStimulus(3'b010, 1'b0, hs);
    seq[0] = 0;
    seq[2] = 0;
    for (int c = 0; c < 12; c++) begin
      setData(0, 5'(seq[0] + 2), 5'(seq[0] + 20), 32'hA0A0_0000 + seq[0]);
      setData(2, 5'(seq[2] + 6), 5'(seq[2] + 26), 32'hA2A2_0000 + seq[2]);
      applyStimulus({seq[2] < 3, 1'b0, seq[0] < 3}, 1'b0, hs);
      seq[0] += int'(hs[0]);
      seq[2] += int'(hs[2]);
    end
    checkOutput("t4_broadcast_count", 64'(grantLog.size()), 64'd7);
    for (int k = 0; k < grantLog.size() && k < 7; k++) begin
      checkOutput("t4_wrap_order", 64'(grantLog[k]), 64'(t4Tab[k]));
    end

    // Flush mid-stream
    resetDut();
    for (int i = 0; i < NS; i++) setData(i, 5'(i + 1), 5'(i + 10), 32'hF000_0000 + i);
    applyStimulus(3'b111, 1'b0, hs);
    checkOutput("t5_hs0", 64'(hs), 64'h7);
    for (int i = 0; i < NS; i++) setData(i, 5'(i + 4), 5'(i + 13), 32'hF100_0000 + i);
    applyStimulus(3'b111, 1'b0, hs);
    checkOutput("t5_hs1", 64'(hs), 64'h7);
    #2;
    checkOutput("t5_pre_flush_cdbus", 64'(cdbus_o), 64'({1'b1, 5'd1, 5'd10, 32'hF000_0000}));
    fu_valid_i = 3'b111;
    flush_i    = 1'b1;
    #1;
    checkOutput("t5_ready_in_flush", 64'(fu_ready_o), 64'd0);
    applyStimulus(3'b111, 1'b1, hs);
    checkOutput("t5_flush_no_hs", 64'(hs), 64'd0);
    #2;
    checkOutput("t5_post_valid", 64'(cdbus_o.valid), 64'd0);
    checkOutput("t5_post_grant", 64'(grant_o), 64'd0);
    checkOutput("t5_post_ready", 64'(fu_ready_o), 64'h7);
    grantLog.delete();
    idleCycles(3);
    for (int i = 0; i < NS; i++) setData(i, 5'(i + 20), 5'(i + 24), 32'hE000_0000 + i);
    applyStimulus(3'b111, 1'b0, hs);
    idleCycles(5);
    checkOutput("t5_broadcast_count", 64'(grantLog.size()), 64'd3);
    for (int k = 0; k < grantLog.size() && k < 3; k++) begin
      checkOutput("t5_rr_reset_order", 64'(grantLog[k]), 64'(t5Tab[k]));
    end

    // Async reset while a broadcast is on the bus
    resetDut();
    setData(0, 5'd7, 5'd9, 32'h5555AAAA);
    applyStimulus(3'b001, 1'b0, hs);
    idleCycles(1);
    #2;
    checkOutput("t6_live_cdbus", 64'(cdbus_o), 64'({1'b1, 5'd7, 5'd9, 32'h5555AAAA}));
    rst = 1'b0;
    clearExp();
    #1;
    checkOutput("t6_async_cdbus", 64'(cdbus_o), 64'd0);
    checkOutput("t6_async_grant", 64'(grant_o), 64'd0);
    checkOutput("t6_async_ready", 64'(fu_ready_o), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    idleCycles(1);
    #2;
    checkOutput("t6_ready_resume", 64'(fu_ready_o), 64'h7);
    setData(2, 5'd31, 5'd31, 32'hFFFFFFFF);
    applyStimulus(3'b100, 1'b0, hs);
    checkOutput("t6_hs", 64'(hs), 64'h4);
    idleCycles(1);
    #2;
    checkOutput("t6_resume_cdbus", 64'(cdbus_o), 64'({1'b1, 5'd31, 5'd31, 32'hFFFFFFFF}));
    checkOutput("t6_resume_grant", 64'(grant_o), 64'h4);
    idleCycles(3);

    for (int i = 0; i < NS; i++) checkOutput("final_drained", 64'(qSize(i)), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
